ddr_rx_deserializer: RTL and testbench

DDR_RX_DESERIALIZER -- requirements
Module: ddr_rx_deserializer

---
 rtl/ddr_rx_pkg.sv | 24 ++
 rtl/ddr_rx_fifo.sv | 58 +++++
 rtl/ddr_rx_deserializer.sv | 153 +++++++++++++++
 tb/tb_ddr_rx_deserializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rx_pkg.sv
// Shared definitions for the DDR receive deserializer: FSM encoding, word
// geometry and the byte packing helper.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = WORD_W / BYTES_PER_WORD;

    // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
    function automatic logic [WORD_W-1:0] shift_in_byte(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] new_byte
    );
        return {new_byte, word[WORD_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/ddr_rx_fifo.sv
// First-word-fall-through word FIFO. A push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module ddr_rx_fifo
    import ddr_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [AW:0]       count
);

    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign w_pop_ok  = pop && (r_count != {CW{1'b0}});
    assign w_push_ok = push && ((r_count < DEPTH_C) || w_pop_ok);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {WORD_W{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rx_deserializer.sv
// DDR pad receive deserializer: gates the pad clock through dummy and capture
// cycles, packs nibble pairs into 32-bit words and buffers them in a FIFO.
module ddr_rx_deserializer
    import ddr_rx_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        word_count,
    input  logic [3:0]        skip_cycles,
    input  logic [LANES-1:0]  din_0,
    input  logic [LANES-1:0]  din_1,
    output logic              sclk_en,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = AW + 2;

    rx_state_t         r_state;
    logic              r_sclk_en;
    logic              r_busy;
    logic              r_done;
    logic              r_push;
    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_words_left;
    logic [3:0]        r_skip_left;

    logic [AW:0]       w_fifo_count;
    logic [WORD_W-1:0] w_pop_data;
    logic [BYTE_W-1:0] w_byte;
    logic              w_pop;
    logic              w_cap;
    logic              w_push_next;
    logic [OCC_W-1:0]  w_occ_next;
    logic              w_room_next;

    assign w_byte      = {din_1, din_0};
    assign w_pop       = word_ready && (w_fifo_count != {(AW + 1){1'b0}});
    assign w_cap       = (r_state == CAPTURE) && r_sclk_en;
    assign w_push_next = w_cap && (r_byte_idx == 2'd3);

    // Next-cycle occupancy counts the word about to be pushed, so a word is only
    // started when its slot is guaranteed by the time it completes.
    assign w_occ_next  = OCC_W'(w_fifo_count) + OCC_W'(r_push) + OCC_W'(w_push_next)
                       - OCC_W'(w_pop);
    assign w_room_next = (w_occ_next < OCC_W'(FIFO_DEPTH));

    assign sclk_en    = r_sclk_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_data  = w_pop_data;
    assign word_valid = (w_fifo_count != {(AW + 1){1'b0}});

    ddr_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_push),
        .push_data (r_word),
        .pop       (word_ready),
        .pop_data  (w_pop_data),
        .count     (w_fifo_count)
    );

    // Burst sequencer; sclk_en is registered, so each branch decides the next cycle's enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sclk_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_push       <= 1'b0;
            r_word       <= {WORD_W{1'b0}};
            r_byte_idx   <= 2'd0;
            r_words_left <= 8'd0;
            r_skip_left  <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_push <= w_push_next;
            if (w_cap) begin
                r_word     <= shift_in_byte(r_word, w_byte);
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            case (r_state)
                IDLE: begin
                    r_sclk_en <= 1'b0;
                    if (start && (word_count != 8'd0)) begin
                        r_busy       <= 1'b1;
                        r_words_left <= word_count;
                        r_byte_idx   <= 2'd0;
                        if (skip_cycles != 4'd0) begin
                            r_state     <= SKIP;
                            r_skip_left <= skip_cycles;
                            r_sclk_en   <= 1'b1;
                        end else begin
                            r_state   <= CAPTURE;
                            r_sclk_en <= w_room_next;
                        end
                    end
                end
                SKIP: begin
                    if (r_skip_left == 4'd1) begin
                        r_state     <= CAPTURE;
                        r_skip_left <= 4'd0;
                        r_sclk_en   <= w_room_next;
                    end else begin
                        r_skip_left <= r_skip_left - 4'd1;
                        r_sclk_en   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (w_push_next) begin
                        r_words_left <= r_words_left - 8'd1;
                        if (r_words_left == 8'd1) begin
                            r_state   <= DRAIN;
                            r_sclk_en <= 1'b0;
                        end else begin
                            r_sclk_en <= w_room_next;
                        end
                    end else if (w_cap) begin
                        r_sclk_en <= 1'b1;
                    end else begin
                        r_sclk_en <= w_room_next;
                    end
                end
                DRAIN: begin
                    r_sclk_en <= 1'b0;
                    if (!r_push && (w_fifo_count == {(AW + 1){1'b0}})) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_sclk_en <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Directed bench for ddr_rx_deserializer with a clock-gated pad device model
// and a direct check of the word FIFO under simultaneous push/pop.
module tb_ddr_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  word_count = 8'd0;
    logic [3:0]  skip_cycles = 4'd0;
    logic [3:0]  din_0;
    logic [3:0]  din_1;
    logic        sclk_en;
    logic        busy;
    logic        done;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;

    logic        f_rst = 1'b1;
    logic        f_push = 1'b0;
    logic        f_pop = 1'b0;
    logic [31:0] f_data = 32'd0;
    logic [31:0] f_out;
    logic [2:0]  f_count;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ddr_rx_deserializer #(.LANES(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .word_count  (word_count),
        .skip_cycles (skip_cycles),
        .din_0       (din_0),
        .din_1       (din_1),
        .sclk_en     (sclk_en),
        .busy        (busy),
        .done        (done),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready)
    );

    ddr_rx_fifo #(.FIFO_DEPTH(4)) u_fifo_chk (
        .clk       (clk),
        .reset     (f_rst),
        .push      (f_push),
        .push_data (f_data),
        .pop       (f_pop),
        .pop_data  (f_out),
        .count     (f_count)
    );

    // Pad device: presents stream[offset] and advances only on gated clocks.
    int         dev_cnt = 0;
    int         dev_base = 0;
    logic [7:0] stream [0:63];
    logic [5:0] dev_ofs;
    logic [7:0] dev_byte;
    always @(posedge clk) if (sclk_en) dev_cnt <= dev_cnt + 1;
    assign dev_ofs  = 6'(dev_cnt - dev_base);
    assign dev_byte = stream[dev_ofs];
    assign din_1    = dev_byte[7:4];
    assign din_0    = dev_byte[3:0];

    logic [31:0] got[$];
    int done_cnt = 0;
    int done_at = 0;
    always @(negedge clk) begin
        if (word_valid && word_ready) got.push_back(word_data);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_at  = got.size();
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int k);
        if (k < got.size()) return got[k];
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic do_start(input logic [7:0] wc, input logic [3:0] sk);
        start = 1'b1;
        word_count = wc;
        skip_cycles = sk;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == d0; i++) tick();
        tick(3);
        check(tag, done_cnt - d0, 1);
    endtask

    initial begin
        int q0;
        int dev0;
        int d0;
        for (int i = 0; i < 64; i++) stream[i] = 8'h00;

        // Reset values
        tick(2);
        check("rst_sclk_en", sclk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_data", word_data, 32'h0);
        reset = 1'b0;
        tick();

        // Basic burst
        for (int i = 0; i < 8; i++) stream[i] = 8'(8'h11 * (i + 1));
        dev_base = dev_cnt; dev0 = dev_cnt; q0 = got.size();
        word_ready = 1'b1;
        do_start(8'd2, 4'd0);
        check("basic_busy_rise", busy, 1);
        wait_done("basic_done", 100);
        check("basic_nwords", got.size() - q0, 2);
        check("basic_word0", got_at(q0), 32'h4433_2211);
        check("basic_word1", got_at(q0 + 1), 32'h8877_6655);
        check("basic_sclk_cycles", dev_cnt - dev0, 8);
        check("basic_busy_low", busy, 0);

        // Dummy cycles: six garbage bytes must not leak into the word
        for (int i = 0; i < 6; i++) stream[i] = 8'hEE;
        for (int i = 0; i < 4; i++) stream[6 + i] = 8'(8'hA1 + i);
        dev_base = dev_cnt; dev0 = dev_cnt; q0 = got.size();
        do_start(8'd1, 4'd6);
        check("skip_sclk_first", sclk_en, 1);
        wait_done("skip_done", 100);
        check("skip_sclk_cycles", dev_cnt - dev0, 10);
        check("skip_word0", got_at(q0), 32'hA4A3_A2A1);

        // Boundary starts
        d0 = done_cnt; dev0 = dev_cnt;
        do_start(8'd0, 4'd0);
        tick(5);
        check("zero_busy", busy, 0);
        check("zero_done", done_cnt - d0, 0);
        check("zero_sclk", dev_cnt - dev0, 0);
        for (int i = 0; i < 4; i++) stream[i] = 8'(8'h31 + i);
        dev_base = dev_cnt; dev0 = dev_cnt; q0 = got.size();
        do_start(8'd1, 4'd0);
        do_start(8'd3, 4'd0);
        wait_done("busy_start_done", 100);
        check("busy_start_nwords", got.size() - q0, 1);
        check("busy_start_word", got_at(q0), 32'h3433_3231);
        check("busy_start_sclk", dev_cnt - dev0, 4);

        // Backpressure
        for (int i = 0; i < 24; i++) stream[i] = 8'(i + 1);
        dev_base = dev_cnt; dev0 = dev_cnt; q0 = got.size();
        word_ready = 1'b0;
        do_start(8'd6, 4'd0);
        tick(40);
        check("bp_stall_bytes", dev_cnt - dev0, 16);
        check("bp_stall_sclk", sclk_en, 0);
        check("bp_valid", word_valid, 1);
        check("bp_head", word_data, 32'h0403_0201);
        tick(3);
        check("bp_head_stable", word_data, 32'h0403_0201);
        check("bp_busy", busy, 1);
        word_ready = 1'b1;
        tick(2);
        word_ready = 1'b0;
        tick(30);
        check("bp_resume_bytes", dev_cnt - dev0, 24);
        check("bp_busy_draining", busy, 1);
        d0 = done_cnt;
        word_ready = 1'b1;
        wait_done("bp_done", 100);
        check("bp_nwords", got.size() - q0, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_word%0d", i), got_at(q0 + i),
                  {8'(4 * i + 4), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1)});
        end
        check("bp_done_after_6th_pop", done_at - q0, 6);

        // Reset at byte index 2 of the second word, with the first word buffered
        for (int i = 0; i < 8; i++) stream[i] = 8'(8'h41 + i);
        dev_base = dev_cnt; dev0 = dev_cnt;
        word_ready = 1'b0;
        do_start(8'd2, 4'd0);
        for (int i = 0; i < 50 && (dev_cnt - dev0) != 6; i++) tick();
        check("mid_reach", dev_cnt - dev0, 6);
        check("mid_pre_valid", word_valid, 1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("mid_sclk_en", sclk_en, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_word_valid", word_valid, 0);
        check("mid_word_data", word_data, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("mid_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 4; i++) stream[i] = 8'(8'h51 + i);
        dev_base = dev_cnt; q0 = got.size();
        word_ready = 1'b1;
        do_start(8'd1, 4'd0);
        wait_done("fresh_done", 100);
        check("fresh_nwords", got.size() - q0, 1);
        check("fresh_word", got_at(q0), 32'h5453_5251);

        // FIFO: push and pop together while full
        f_rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        f_push = 1'b0;
        check("ff_full_count", f_count, 4);
        check("ff_full_head", f_out, 32'hD000_0000);
        f_push = 1'b1; f_pop = 1'b1; f_data = 32'hD000_0004;
        tick();
        f_push = 1'b0; f_pop = 1'b0;
        check("ff_pp_count", f_count, 4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ff_order%0d", i), f_out, 32'hD000_0000 + 32'(i));
            f_pop = 1'b1;
            tick();
            f_pop = 1'b0;
        end
        check("ff_empty_count", f_count, 0);
        f_pop = 1'b1;
        tick();
        f_pop = 1'b0;
        check("ff_empty_pop", f_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
